// File: rtl/uart_mem_loader_ctrl_pkg.sv
// Shared definitions for the UART memory loader: loader FSM encoding, memory
// and direction codes used by the UART RX/TX blocks and the loader.
package uart_mem_loader_ctrl_pkg;

  localparam int LDR_ADDR_W       = 9;
  localparam int LDR_DATA_W       = 32;
  localparam int LDR_DRAIN_CYCLES = 4;

  localparam logic MEM_IMEM = 1'b0;
  localparam logic MEM_DMEM = 1'b1;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_GRANT   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_READ    = 3'd4,
    ST_RD_CAP  = 3'd5,
    ST_TX_WAIT = 3'd6,
    ST_RELEASE = 3'd7
  } ldr_state_e;

  // States in which the loader owns a memory port and drives address/data.
  function automatic logic ldr_owns_port(input ldr_state_e st);
    return (st == ST_GRANT) || (st == ST_WRITE) || (st == ST_READ) || (st == ST_RD_CAP);
  endfunction

  // States in which the CPU pipeline must stay frozen.
  function automatic logic ldr_stalls_cpu(input ldr_state_e st);
    return (st != ST_IDLE) && (st != ST_RELEASE);
  endfunction

endpackage

// File: rtl/uart_mem_loader_ctrl.sv
// UART packet sequencer: stalls the CPU, drains the pipeline, borrows the IMEM or
// DMEM port for one write or read, returns read data to the UART TX, then releases.
module uart_mem_loader_ctrl
  import uart_mem_loader_ctrl_pkg::*;
#(
  parameter int ADDR_W       = LDR_ADDR_W,
  parameter int DATA_W       = LDR_DATA_W,
  parameter int DRAIN_CYCLES = LDR_DRAIN_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic              pkt_rw,
  input  logic              pkt_mem_type,
  input  logic [ADDR_W-1:0] pkt_addr,
  input  logic [DATA_W-1:0] pkt_data,
  output logic              cpu_stall,
  output logic              imem_sel_ldr,
  output logic              dmem_sel_ldr,
  output logic              ldr_we,
  output logic [ADDR_W-1:0] ldr_addr,
  output logic [DATA_W-1:0] ldr_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              overflow
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  ldr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic              mem_type_q, mem_type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;

  // State and packet registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      mem_type_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      mem_type_q <= mem_type_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic; packets arriving outside IDLE (including RELEASE) are dropped.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    mem_type_d = mem_type_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;

    if (pkt_valid && (state_q != ST_IDLE)) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (pkt_valid) begin
          rw_d       = pkt_rw;
          mem_type_d = pkt_mem_type;
          addr_d     = pkt_addr;
          wdata_d    = pkt_data;
          cnt_d      = CNT_LOAD;
          state_d    = ST_DRAIN;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_GRANT;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (rw_q == RW_WRITE) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WRITE:  state_d = ST_RELEASE;
      ST_READ:   state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        // Address has been stable since GRANT, so the synchronous read data is valid now.
        tx_data_d = (mem_type_q == MEM_DMEM) ? dmem_rdata : imem_rdata;
        state_d   = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (!tx_busy) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_TX_WAIT;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode from the registered state and packet fields.
  always_comb begin
    cpu_stall    = ldr_stalls_cpu(state_q);
    imem_sel_ldr = ldr_owns_port(state_q) && (mem_type_q == MEM_IMEM);
    dmem_sel_ldr = ldr_owns_port(state_q) && (mem_type_q == MEM_DMEM);
    ldr_we       = (state_q == ST_WRITE);
    busy         = (state_q != ST_IDLE);
    tx_start     = (state_q == ST_TX_WAIT) && !tx_busy;
    if (ldr_owns_port(state_q)) begin
      ldr_addr  = addr_q;
      ldr_wdata = wdata_q;
    end else begin
      ldr_addr  = '0;
      ldr_wdata = '0;
    end
  end

  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_mem_loader_ctrl.sv
// Scoreboard bench for uart_mem_loader_ctrl with behavioural IMEM/DMEM models.
module tb_uart_mem_loader_ctrl;
  import uart_mem_loader_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_valid, pkt_rw, pkt_mem_type;
  logic [8:0]  pkt_addr;
  logic [31:0] pkt_data;
  logic        cpu_stall, imem_sel_ldr, dmem_sel_ldr, ldr_we;
  logic [8:0]  ldr_addr;
  logic [31:0] ldr_wdata, imem_rdata, dmem_rdata, tx_data;
  logic        tx_start, tx_busy, busy, overflow;

  typedef struct {
    logic        rw;
    logic        mt;
    logic [8:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] imem_m [512];
  logic [31:0] dmem_m [512];
  logic [31:0] ref_imem [512];
  logic [31:0] ref_dmem [512];
  int n_checks = 0;
  int n_fail   = 0;

  uart_mem_loader_ctrl dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_rw(pkt_rw),
    .pkt_mem_type(pkt_mem_type), .pkt_addr(pkt_addr), .pkt_data(pkt_data),
    .cpu_stall(cpu_stall), .imem_sel_ldr(imem_sel_ldr), .dmem_sel_ldr(dmem_sel_ldr),
    .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .imem_rdata(imem_rdata), .dmem_rdata(dmem_rdata), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; pipeline side parks on address 0.
  always @(posedge clk) begin
    if (ldr_we && imem_sel_ldr) imem_m[ldr_addr] <= ldr_wdata;
    if (ldr_we && dmem_sel_ldr) dmem_m[ldr_addr] <= ldr_wdata;
    imem_rdata <= imem_m[imem_sel_ldr ? ldr_addr : 9'd0];
    dmem_rdata <= dmem_m[dmem_sel_ldr ? ldr_addr : 9'd0];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_stall"}, 64'(cpu_stall), 64'd0);
    check_eq({tag, "_sel"},   64'({imem_sel_ldr, dmem_sel_ldr}), 64'd0);
    check_eq({tag, "_we"},    64'(ldr_we), 64'd0);
    check_eq({tag, "_busy"},  64'(busy), 64'd0);
    check_eq({tag, "_txs"},   64'(tx_start), 64'd0);
  endtask

  // Drives one packet and follows it cycle by cycle until the loader is idle again.
  task automatic run_pkt(input logic rw, input logic mt, input logic [8:0] addr,
                         input logic [31:0] data, input int busy_len, input int dup_at);
    exp_t e;
    int   we_cnt = 0, we_cyc = -1, tx_cyc = -1, fall_cyc = -1, exp_tx;
    bit   done = 1'b0;
    e.rw = rw; e.mt = mt; e.addr = addr;
    if (rw == RW_WRITE) begin
      e.data = data;
      if (mt == MEM_DMEM) ref_dmem[addr] = data; else ref_imem[addr] = data;
    end else begin
      e.data = (mt == MEM_DMEM) ? ref_dmem[addr] : ref_imem[addr];
    end
    sb_q.push_back(e);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      pkt_valid = (k == 0) || (k == dup_at);
      if (k == 0) begin
        pkt_rw = rw; pkt_mem_type = mt; pkt_addr = addr; pkt_data = data;
      end else if (k == dup_at) begin
        pkt_rw = RW_WRITE; pkt_mem_type = MEM_DMEM; pkt_addr = addr + 9'd1; pkt_data = ~data;
      end
      tx_busy = (k < busy_len);
      #1;
      check_eq("sel_excl", 64'(imem_sel_ldr & dmem_sel_ldr), 64'd0);
      if (k == 0) check_eq("stall_pre", 64'(cpu_stall), 64'd0);
      if (k == 1) check_eq("stall_rise", 64'(cpu_stall), 64'd1);
      if (ldr_we) begin
        we_cnt++;
        we_cyc = k;
        check_eq("sb_pending", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("we_addr", 64'(ldr_addr), 64'(e.addr));
          check_eq("we_data", 64'(ldr_wdata), 64'(e.data));
          check_eq("we_dsel", 64'(dmem_sel_ldr), 64'(e.mt));
          check_eq("we_isel", 64'(imem_sel_ldr), 64'(!e.mt));
        end
      end
      if (tx_start) begin
        tx_cyc = k;
        check_eq("tx_busy_low", 64'(tx_busy), 64'd0);
        check_eq("tx_sel_off", 64'({imem_sel_ldr, dmem_sel_ldr}), 64'd0);
        check_eq("sb_pending", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("tx_data", 64'(tx_data), 64'(e.data));
        end
      end
      if (k > 1 && fall_cyc < 0 && !cpu_stall) fall_cyc = k;
      if (k >= 2 && !busy) done = 1'b1;
    end
    pkt_valid = 1'b0;
    tx_busy   = 1'b0;
    check_eq("timeout", 64'(done), 64'd1);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    if (rw == RW_WRITE) begin
      check_eq("we_count", 64'(we_cnt), 64'd1);
      check_eq("we_cycle", 64'(we_cyc), 64'd6);
      check_eq("stall_fall", 64'(fall_cyc), 64'd7);
      check_eq("no_tx_on_write", 64'(tx_cyc), 64'(-1));
    end else begin
      exp_tx = (busy_len > 8) ? busy_len : 8;
      check_eq("rd_no_we", 64'(we_cnt), 64'd0);
      check_eq("tx_cycle", 64'(tx_cyc), 64'(exp_tx));
      check_eq("stall_fall", 64'(fall_cyc), 64'(exp_tx + 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      imem_m[i]   = 32'h1000_0000 + 32'(i);
      dmem_m[i]   = 32'h2000_0000 ^ 32'(i * 7);
      ref_imem[i] = imem_m[i];
      ref_dmem[i] = dmem_m[i];
    end
    imem_m[511] = 32'h0000_0013; ref_imem[511] = 32'h0000_0013;
    reset = 1'b1; pkt_valid = 1'b0; pkt_rw = 1'b0; pkt_mem_type = 1'b0;
    pkt_addr = 9'd0; pkt_data = 32'd0; tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    check_eq("reset_ovf", 64'(overflow), 64'd0);
    check_eq("reset_txd", 64'(tx_data), 64'd0);
    check_eq("reset_addr", 64'({ldr_addr, ldr_wdata}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_pkt(RW_WRITE, MEM_DMEM, 9'h005, 32'hDEAD_BEEF, 0, -1);
    check_eq("dmem_written", 64'(dmem_m[5]), 64'h0000_0000_DEAD_BEEF);
    run_pkt(RW_READ, MEM_IMEM, 9'h1FF, 32'h0, 0, -1);
    run_pkt(RW_READ, MEM_DMEM, 9'h005, 32'h0, 0, -1);
    run_pkt(RW_WRITE, MEM_IMEM, 9'h000, 32'hCAFE_F00D, 0, -1);
    run_pkt(RW_READ, MEM_IMEM, 9'h000, 32'h0, 0, -1);
    check_eq("txd_hold", 64'(tx_data), 64'h0000_0000_CAFE_F00D);
    run_pkt(RW_READ, MEM_DMEM, 9'h100, 32'h0, 20, -1);

    check_eq("ovf_before", 64'(overflow), 64'd0);
    run_pkt(RW_WRITE, MEM_DMEM, 9'h007, 32'h1234_5678, 0, 2);
    check_eq("ovf_set", 64'(overflow), 64'd1);
    check_eq("no_dup_write", 64'(dmem_m[8]), 64'(ref_dmem[8]));

    @(negedge clk);
    pkt_valid = 1'b1; pkt_rw = RW_WRITE; pkt_mem_type = MEM_DMEM;
    pkt_addr = 9'h020; pkt_data = 32'hBAD0_BAD0;
    @(negedge clk);
    pkt_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("mid_in_drain", 64'(cpu_stall), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    check_eq("async_rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("no_aborted_write", 64'(dmem_m[32]), 64'(ref_dmem[32]));

    run_pkt(RW_READ, MEM_DMEM, 9'h007, 32'h0, 0, -1);
    check_eq("ovf_clear", 64'(overflow), 64'd0);
    run_pkt(RW_WRITE, MEM_DMEM, 9'h010, 32'h0F0F_0F0F, 0, 7);
    check_eq("ovf_release", 64'(overflow), 64'd1);
    check_eq("no_release_write", 64'(dmem_m[17]), 64'(ref_dmem[17]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
